pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 66, payload width (IR 32 + pc4 32 + bd 1 + WAPC 1).
REQ-002 Parameter BUBBLE, default all-zero, value driven on out_data while out_valid=0 (nop).
REQ-003 The design SHALL have exactly one clock; reset SHALL be asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 clr_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous kill of all held entries (branch/exception redirect).
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a live entry.
REQ-011 out_ready  input  1  downstream consumes (deasserted = stall).
REQ-012 out_data  output  DATA_W  head entry, or BUBBLE when out_valid=0.
REQ-013 count  output  2  entries held (0..2).

Function
REQ-014 Storage SHALL be two registers: main (drives out_data) and skid; each has a valid bit.
REQ-015 States SHALL be EMPTY (count 0), ONE (main valid), FULL (main + skid valid); skid valid without main valid never occurs.
REQ-016 Accept = in_valid & in_ready; consume = out_valid & out_ready; both evaluated at the same rising edge.
REQ-017 in_ready SHALL equal !skid_valid, registered.
REQ-018 EMPTY: accept -> ONE, main <= in_data; no accept -> stay.
REQ-019 ONE: accept & consume -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; consume only -> EMPTY; neither -> stay.
REQ-020 FULL: consume -> ONE, main <= skid, skid cleared; no consume -> stay, in_ready=0.
REQ-021 Latency: data accepted at edge N SHALL appear on out_data after edge N with out_valid=1 when the stage was EMPTY, or ONE with a simultaneous consume.
REQ-022 Sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-023 Order SHALL be strict FIFO; no entry duplicated or dropped except by flush.
REQ-024 Stalled main (out_valid=1, out_ready=0) SHALL hold out_data unchanged.
REQ-025 flush=1 at an edge SHALL give EMPTY, count=0, in_ready=1, out_data=BUBBLE; a simultaneous accept is discarded; flush overrides consume and accept.
REQ-026 When out_valid=0, out_data SHALL equal BUBBLE regardless of stale register contents.
REQ-027 count SHALL equal main_valid + skid_valid each cycle.

Reset
REQ-028 clr_n=0 SHALL immediately, without a clock edge, set: both valid bits 0; out_valid=0; in_ready=1; count=0; out_data=BUBBLE; skid and main payloads 0.
REQ-029 Reset mid-operation (any state) SHALL discard all entries; first accept after clr_n rises behaves as from EMPTY.
REQ-030 Inputs during reset SHALL be ignored; no accept occurs while clr_n=0.

Verification
REQ-031 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive edges -> out_data 1,2,3,4 one edge later each, count=1 steady, in_ready=1 throughout.
REQ-032 Stall/skid: stream A,B,C; out_ready=0 after A reaches output -> B into skid, count=2, in_ready=0, C held upstream; out_ready=1 -> A, B, C emitted in order, no loss.
REQ-033 Flush: FULL with A,B plus in_valid=1 with C and flush=1 at the same edge -> count=0, out_valid=0, out_data=BUBBLE, C never appears.
REQ-034 Async reset: FULL state, drop clr_n mid-cycle -> out_valid=0, count=0, in_ready=1 before the next edge; release, send D -> D out after one edge.
REQ-035 Random: random in_valid/out_ready/flush (10% flush) for 10k cycles vs scoreboard FIFO model -> zero mismatches, count never 3, out_data=BUBBLE whenever out_valid=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline register: main drives the output and skid absorbs one
// extra beat, so in_ready can be a flop with no combinational path from out_ready.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W = 66,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              main_valid, skid_valid;
    logic              accept, consume;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);
    assign accept     = in_valid & in_ready_q;
    assign consume    = main_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A redirect kills everything held, including a same-edge accept.
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_q : BUBBLE;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the stage is modelled as a FIFO of capacity two
// whose head must appear on out_data, with BUBBLE shown whenever it is empty.
module tb_pipe_skid_reg;

    localparam int DW = 66;
    localparam logic [DW-1:0] BUBBLE_V = '0;

    logic          clk       = 1'b0;
    logic          clr_n     = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    logic [DW-1:0] exp_q[$];
    bit            had_entry = 1'b0;
    int            checks    = 0;
    int            failures  = 0;

    pipe_skid_reg #(.DATA_W(DW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Inputs change just after the falling edge; an accepted beat enters the model here.
    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                  input logic r, input logic f);
        @(negedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (clr_n && v && exp_q.size() < 2) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic reset_checks(input string tag);
        check_output({tag, "_out_valid"}, DW'(out_valid), '0);
        check_output({tag, "_count"},     DW'(count),     '0);
        check_output({tag, "_in_ready"},  DW'(in_ready),  DW'(1));
        check_output({tag, "_out_data"},  out_data,       BUBBLE_V);
    endtask

    // Monitor: retire the edge's consume or flush, then compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!clr_n) begin
                had_entry = 1'b0;
            end else begin
                if (flush) begin
                    exp_q.delete();
                end else if (had_entry && out_ready) begin
                    exp_q.delete(0);
                end
                check_output("out_valid", DW'(out_valid), DW'(exp_q.size() > 0));
                check_output("count",     DW'(count),     DW'(exp_q.size()));
                check_output("in_ready",  DW'(in_ready),  DW'(exp_q.size() < 2));
                check_output("out_data",  out_data, (exp_q.size() > 0) ? exp_q[0] : BUBBLE_V);
                had_entry = (exp_q.size() > 0);
            end
        end
    end

    initial begin
        #1 clr_n = 1'b0;
        #1 reset_checks("por");
        @(negedge clk);
        #3 clr_n = 1'b1;

        // Back-to-back streaming
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, DW'(i), 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Stall with skid, then drain in order
        apply_stimulus(1'b1, DW'(66'h0A), 1'b1, 1'b0);
        apply_stimulus(1'b1, DW'(66'h0B), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h0C), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h0C), 1'b1, 1'b0);
        apply_stimulus(1'b1, DW'(66'h0C), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush while full and offering a new beat
        apply_stimulus(1'b1, DW'(66'h1A), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h1B), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h1C), 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush with one held entry and a simultaneous accept and consume
        apply_stimulus(1'b1, DW'(66'h2A), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h2C), 1'b1, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while full, then one beat from empty
        apply_stimulus(1'b1, DW'(66'h3A), 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(66'h3B), 1'b0, 1'b0);
        @(negedge clk);
        #3 clr_n = 1'b0;
        #1 reset_checks("async");
        exp_q.delete();
        apply_stimulus(1'b1, DW'(66'h3E), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1 clr_n = 1'b1;
        apply_stimulus(1'b1, DW'(66'h0D), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            logic [95:0] r96;
            r96 = {$urandom, $urandom, $urandom};
            apply_stimulus(($urandom_range(0, 1) == 1), r96[DW-1:0],
                           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
